// File: rtl/ff_serial_scheduler_pkg.sv
// Shared types and constants for the bit-serial flop scheduler.
package ff_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ff_sched_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Line cycles occupied by one frame: start bit + data bits + stop bit.
  function automatic int frame_len(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/ff_serial_scheduler_if.sv
// Request bus between N requesters and the serial scheduler.
// Handshake: a requester raises req_valid[i] with req_data[i*W +: W] stable and
// holds both until req_ready[i] pulses for one cycle; that cycle is the transfer.
interface ff_serial_scheduler_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/ff_serial_scheduler_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 (mod N) and grants the first requester found.
module ff_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);
  localparam int GW = $clog2(N);
  localparam logic [GW:0] N_W = (GW+1)'(N);

  logic [GW:0]   sum;
  logic [GW-1:0] idx;
  logic          found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, last_grant} + (GW+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[GW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/ff_serial_scheduler.sv
// Shares one flip-flop cell among N requesters as a framed, LSB-first serial line,
// verifying every driven bit against the flop output one cycle later.
module ff_serial_scheduler
  import ff_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ff_serial_scheduler_if.slave req,
  output logic                 ff_sel,
  output logic                 ff_din,
  input  logic                 ff_dout,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 done,
  output logic                 err,
  output ff_sched_state_e      dbg_state
);
  localparam int GW = $clog2(N);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  ff_sched_state_e state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic            exp_q, exp_d;
  logic            chk_q, chk_d;
  logic            err_acc_q, err_acc_d;
  logic            done_q, done_d;

  logic [N-1:0]    gnt;
  logic [GW-1:0]   gnt_id;
  logic            arb_en;
  logic            mismatch;

  // Gating with reset keeps req_ready low while reset is held.
  assign arb_en = (state_q == IDLE) && reset;

  ff_rr_arbiter #(.N(N)) u_arb (
    .req        (req.req_valid),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  assign req.req_ready = gnt;
  assign mismatch      = chk_q && (ff_dout != exp_q);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    err_acc_d    = err_acc_q | mismatch;
    ff_sel       = 1'b0;
    ff_din       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          for (int i = 0; i < N; i++) begin
            if (gnt[i]) shift_d = req.req_data[i*W +: W];
          end
          last_grant_d = gnt_id;
          grant_id_d   = gnt_id;
          cnt_d        = '0;
          err_acc_d    = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        ff_sel  = 1'b1;
        ff_din  = START_BIT;
        state_d = DATA;
      end
      DATA: begin
        ff_sel  = 1'b1;
        ff_din  = shift_q[0];
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_LAST) state_d = STOP;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      STOP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy   = (state_q != IDLE);
    exp_d  = ff_sel ? ff_din : STOP_BIT;
    chk_d  = busy;
    done_d = (state_q == STOP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= GW'(N - 1);
      grant_id_q   <= '0;
      exp_q        <= STOP_BIT;
      chk_q        <= 1'b0;
      err_acc_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      exp_q        <= exp_d;
      chk_q        <= chk_d;
      err_acc_q    <= err_acc_d;
      done_q       <= done_d;
    end
  end

  // The stop bit is only checked in the done cycle itself, so fold it in here.
  assign done      = done_q;
  assign err       = done_q && (err_acc_q || mismatch);
  assign grant_id  = grant_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ff_serial_scheduler.sv
// Directed bench for ff_serial_scheduler: two instances (N=4/W=8 and N=2/W=1), each
// driving a behavioural flip-flop whose output can be overridden to inject readback faults.
module tb_ff_serial_scheduler;
  import ff_sched_pkg::*;

  localparam int NA = 4;
  localparam int WA = 8;
  localparam int NB = 2;
  localparam int WB = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  ff_serial_scheduler_if #(.N(NA), .W(WA)) rq_a ();
  ff_serial_scheduler_if #(.N(NB), .W(WB)) rq_b ();

  logic            sel_a, din_a, dout_a, busy_a, done_a, err_a, line_a;
  logic [1:0]      gid_a;
  ff_sched_state_e st_a;
  logic            frc_a_en, frc_a_val;

  logic            sel_b, din_b, dout_b, busy_b, done_b, err_b, line_b;
  logic [0:0]      gid_b;
  ff_sched_state_e st_b;

  ff_serial_scheduler #(.N(NA), .W(WA)) dut_a (
    .clk(clk), .reset(reset), .req(rq_a),
    .ff_sel(sel_a), .ff_din(din_a), .ff_dout(dout_a),
    .busy(busy_a), .grant_id(gid_a), .done(done_a), .err(err_a), .dbg_state(st_a)
  );

  ff_serial_scheduler #(.N(NB), .W(WB)) dut_b (
    .clk(clk), .reset(reset), .req(rq_b),
    .ff_sel(sel_b), .ff_din(din_b), .ff_dout(dout_b),
    .busy(busy_b), .grant_id(gid_b), .done(done_b), .err(err_b), .dbg_state(st_b)
  );

  // Flip-flop cells: reset to 0, sel=0 drives the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) line_a <= 1'b0;
    else        line_a <= sel_a ? din_a : 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) line_b <= 1'b0;
    else        line_b <= sel_b ? din_b : 1'b1;
  end
  assign dout_a = frc_a_en ? frc_a_val : line_a;
  assign dout_b = line_b;

  task automatic do_reset;
    reset          = 1'b0;
    rq_a.req_valid = '0;
    rq_a.req_data  = '0;
    rq_b.req_valid = '0;
    rq_b.req_data  = '0;
    frc_a_en       = 1'b0;
    frc_a_val      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset          = 1'b0;
    rq_a.req_valid = '0;
    rq_b.req_valid = '0;
    frc_a_en       = 1'b0;
    @(negedge clk);
    n_checks++; if (sel_a !== 1'b0)   begin n_fail++; $display("FAIL reset_sel: got %b want 0", sel_a); end
    n_checks++; if (din_a !== 1'b0)   begin n_fail++; $display("FAIL reset_din: got %b want 0", din_a); end
    n_checks++; if (rq_a.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", rq_a.req_ready); end
    n_checks++; if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if (gid_a !== 2'd0)   begin n_fail++; $display("FAIL reset_gid: got %0d want 0", gid_a); end
    n_checks++; if (done_a !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_checks++; if (err_a !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b want 0", err_a); end
    n_checks++; if (st_a !== IDLE)    begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", st_a); end
  endtask

  task automatic test_single;
    logic [WA+1:0] fr;
    logic          exp_line;
    do_reset();
    fr = {1'b1, 8'hA5, 1'b0};
    rq_a.req_data[2*WA +: WA] = 8'hA5;
    rq_a.req_valid = 4'b0100;
    @(negedge clk);
    n_checks++; if (rq_a.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", rq_a.req_ready); end
    for (int c = 1; c <= WA + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) rq_a.req_valid = '0;
      @(negedge clk);
      exp_line = (c >= 2) ? fr[c-2] : 1'b1;
      n_checks++; if (line_a !== exp_line) begin n_fail++; $display("FAIL single_line c=%0d: got %b want %b", c, line_a, exp_line); end
      n_checks++; if (busy_a !== (c <= WA + 2)) begin n_fail++; $display("FAIL single_busy c=%0d: got %b", c, busy_a); end
      n_checks++; if (done_a !== (c == WA + 3)) begin n_fail++; $display("FAIL single_done c=%0d: got %b", c, done_a); end
      if (c == WA + 3) begin
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err_a); end
        n_checks++; if (gid_a !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d want 2", gid_a); end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [7:0]    d [4];
    logic [WA+1:0] fr;
    logic [NA-1:0] exp_rdy;
    logic          exp_line, exp_done;
    int            f, p;
    do_reset();
    d = '{8'h3C, 8'h81, 8'h5A, 8'hF0};
    for (int i = 0; i < NA; i++) rq_a.req_data[i*WA +: WA] = d[i];
    rq_a.req_valid = 4'b1111;
    for (int c = 0; c <= 44; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      f        = c / 11;
      p        = c % 11;
      exp_rdy  = (p == 0) ? (4'b0001 << (f % 4)) : 4'b0000;
      exp_done = (p == 0) && (f > 0);
      fr       = {1'b1, d[f % 4], 1'b0};
      exp_line = (p >= 2) ? fr[p-2] : 1'b1;
      n_checks++; if (rq_a.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready c=%0d: got %b want %b", c, rq_a.req_ready, exp_rdy); end
      n_checks++; if (done_a !== exp_done) begin n_fail++; $display("FAIL rr_done c=%0d: got %b want %b", c, done_a, exp_done); end
      n_checks++; if (line_a !== exp_line) begin n_fail++; $display("FAIL rr_line c=%0d: got %b want %b", c, line_a, exp_line); end
      if (exp_done) begin
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rr_err c=%0d: got %b want 0", c, err_a); end
      end
    end
    @(posedge clk); #1;
    rq_a.req_valid = '0;
  endtask

  task automatic test_readback_fault;
    do_reset();
    rq_a.req_data[0 +: WA] = 8'h00;
    rq_a.req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (rq_a.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rb_ready0: got %b want 0001", rq_a.req_ready); end
    for (int c = 1; c <= WA + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) rq_a.req_valid = '0;
      if (c == 6) begin frc_a_en = 1'b1; frc_a_val = 1'b1; end
      if (c == 7) frc_a_en = 1'b0;
      @(negedge clk);
      if (c == WA + 3) begin
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rb_done: got %b want 1", done_a); end
        n_checks++; if (err_a !== 1'b1)  begin n_fail++; $display("FAIL rb_err: got %b want 1", err_a); end
      end
    end
    @(posedge clk); #1;
    rq_a.req_data[1*WA +: WA] = 8'h00;
    rq_a.req_valid = 4'b0010;
    @(negedge clk);
    n_checks++; if (rq_a.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rb_ready1: got %b want 0010", rq_a.req_ready); end
    for (int c = 1; c <= WA + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) rq_a.req_valid = '0;
      @(negedge clk);
      if (c == WA + 3) begin
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rb_clean_done: got %b want 1", done_a); end
        n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL rb_clean_err: got %b want 0", err_a); end
        n_checks++; if (gid_a !== 2'd1)  begin n_fail++; $display("FAIL rb_clean_gid: got %0d want 1", gid_a); end
      end
    end
  endtask

  task automatic test_stop_fault;
    do_reset();
    rq_a.req_data[3*WA +: WA] = 8'hFF;
    rq_a.req_valid = 4'b1000;
    @(negedge clk);
    n_checks++; if (rq_a.req_ready !== 4'b1000) begin n_fail++; $display("FAIL stop_ready: got %b want 1000", rq_a.req_ready); end
    for (int c = 1; c <= WA + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) rq_a.req_valid = '0;
      if (c == WA + 3) begin frc_a_en = 1'b1; frc_a_val = 1'b0; end
      @(negedge clk);
      if (c == WA + 2) begin
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL stop_early_done: got %b want 0", done_a); end
      end
      if (c == WA + 3) begin
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL stop_done: got %b want 1", done_a); end
        n_checks++; if (err_a !== 1'b1)  begin n_fail++; $display("FAIL stop_err: got %b want 1", err_a); end
      end
    end
    @(posedge clk); #1;
    frc_a_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic [WA+1:0] fr;
    logic          exp_line;
    do_reset();
    rq_a.req_data[1*WA +: WA] = 8'hC3;
    rq_a.req_valid = 4'b0010;
    @(negedge clk);
    n_checks++; if (rq_a.req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_ready: got %b want 0010", rq_a.req_ready); end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) rq_a.req_valid = '0;
      if (c == 6) reset = 1'b0;
      @(negedge clk);
      if (c == 5) begin
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy_a); end
      end
    end
    n_checks++; if (sel_a !== 1'b0)  begin n_fail++; $display("FAIL mid_sel: got %b want 0", sel_a); end
    n_checks++; if (din_a !== 1'b0)  begin n_fail++; $display("FAIL mid_din: got %b want 0", din_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy_a); end
    n_checks++; if (gid_a !== 2'd0)  begin n_fail++; $display("FAIL mid_gid: got %0d want 0", gid_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done_a); end
    n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL mid_err: got %b want 0", err_a); end
    n_checks++; if (st_a !== IDLE)   begin n_fail++; $display("FAIL mid_state: got %0d want IDLE", st_a); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL mid_no_done k=%0d: got %b want 0", k, done_a); end
      @(posedge clk); #1;
    end
    fr = {1'b1, 8'h96, 1'b0};
    rq_a.req_data[0 +: WA]    = 8'h96;
    rq_a.req_data[2*WA +: WA] = 8'h0F;
    rq_a.req_valid = 4'b0101;
    @(negedge clk);
    n_checks++; if (rq_a.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant: got %b want 0001", rq_a.req_ready); end
    for (int c = 1; c <= WA + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) rq_a.req_valid = '0;
      @(negedge clk);
      exp_line = (c >= 2) ? fr[c-2] : 1'b1;
      n_checks++; if (line_a !== exp_line) begin n_fail++; $display("FAIL mid_line c=%0d: got %b want %b", c, line_a, exp_line); end
      if (c == WA + 3) begin
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL mid_post_done: got %b want 1", done_a); end
        n_checks++; if (err_a !== 1'b0)  begin n_fail++; $display("FAIL mid_post_err: got %b want 0", err_a); end
      end
    end
  endtask

  task automatic test_back_to_back_w1;
    logic [8:0]    lb;
    logic [NB-1:0] exp_rdy;
    logic          exp_done;
    do_reset();
    lb = 9'b100111011;
    rq_b.req_data  = 2'b01;
    rq_b.req_valid = 2'b11;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) rq_b.req_valid[0] = 1'b0;
        if (c == 5) rq_b.req_valid[1] = 1'b0;
      end
      @(negedge clk);
      exp_rdy  = (c == 0) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      exp_done = (c == 4) || (c == 8);
      n_checks++; if (rq_b.req_ready !== exp_rdy) begin n_fail++; $display("FAIL w1_ready c=%0d: got %b want %b", c, rq_b.req_ready, exp_rdy); end
      n_checks++; if (done_b !== exp_done) begin n_fail++; $display("FAIL w1_done c=%0d: got %b want %b", c, done_b, exp_done); end
      n_checks++; if (line_b !== lb[c]) begin n_fail++; $display("FAIL w1_line c=%0d: got %b want %b", c, line_b, lb[c]); end
      if (exp_done) begin
        n_checks++; if (err_b !== 1'b0) begin n_fail++; $display("FAIL w1_err c=%0d: got %b want 0", c, err_b); end
      end
    end
    n_checks++; if (gid_b !== 1'b1) begin n_fail++; $display("FAIL w1_gid: got %0d want 1", gid_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_readback_fault();
    test_stop_fault();
    test_reset_mid_frame();
    test_back_to_back_w1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
